mac_seq_ctrl: RTL and testbench

Sequencer for one pipelined MAC. It accepts a start request carrying a scratchpad base address and streams KERNEL_SIZE iact/wght pairs from the scratchpads into the MAC. It then issues the flush and dout-enable strobes and returns the 32-bit accumulated result over a valid/ready handshake. It sits between the PE-level scheduler and the MAC instance, and owns both MAC enables.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and datapath constants.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FETCH,
        ST_TAIL,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int KERNEL_SIZE_DEFAULT = 7 * 7;
    localparam int PSUM_WIDTH          = 32;
    localparam int INIT_CYCLES         = 3;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequencer that streams one kernel of scratchpad operands into a pipelined MAC and returns the sum.
// Optional feature: define MAC_SEQ_CTRL_RELU_EN to clamp negative results to zero at capture.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_BITWIDTH = 8,
    parameter int KERNEL_SIZE   = KERNEL_SIZE_DEFAULT,
    parameter int ADDR_BITWIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     start_ready,
    input  logic [ADDR_BITWIDTH-1:0] base_addr,
    output logic                     spad_ren,
    output logic [ADDR_BITWIDTH-1:0] spad_raddr,
    input  logic [DATA_BITWIDTH-1:0] spad_iact,
    input  logic [DATA_BITWIDTH-1:0] spad_wght,
    output logic                     en_MAC_din,
    output logic                     en_MAC_dout,
    output logic [DATA_BITWIDTH-1:0] mac_iact,
    output logic [DATA_BITWIDTH-1:0] mac_wght,
    input  logic [PSUM_WIDTH-1:0]    mac_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PSUM_WIDTH-1:0]    out_data,
    output logic                     busy
);

    localparam logic [ADDR_BITWIDTH-1:0] K_LAST    = ADDR_BITWIDTH'(KERNEL_SIZE - 1);
    localparam logic [1:0]               INIT_LAST = 2'(INIT_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [ADDR_BITWIDTH-1:0]   k_q, k_d;
    logic [ADDR_BITWIDTH-1:0]   spad_raddr_q, spad_raddr_d;
    logic                       spad_ren_q, spad_ren_d;
    logic                       data_beat_q, data_beat_d;
    logic                       en_din_q, en_din_d;
    logic                       en_dout_q, en_dout_d;
    logic                       start_ready_q, start_ready_d;
    logic                       busy_q, busy_d;
    logic                       out_valid_q, out_valid_d;
    logic [PSUM_WIDTH-1:0]      out_data_q, out_data_d;
    logic [PSUM_WIDTH-1:0]      capture_value;
    logic                       init_strobe;

    always_comb begin
`ifdef MAC_SEQ_CTRL_RELU_EN
        capture_value = mac_dout[PSUM_WIDTH-1] ? '0 : mac_dout;
`else
        capture_value = mac_dout;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        spad_raddr_d = spad_raddr_q;
        out_data_d   = out_data_q;
        init_strobe  = 1'b0;

        case (state_q)
            ST_INIT: begin
                // First INIT cycle pushes zero operands with dout enabled, wiping any stale psum.
                init_strobe = (cnt_q == 2'd0);
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    k_d          = '0;
                    spad_raddr_d = base_addr;
                end
            end
            ST_FETCH: begin
                if (k_q == K_LAST) begin
                    state_d = ST_TAIL;
                end else begin
                    k_d          = k_q + ADDR_BITWIDTH'(1);
                    spad_raddr_d = spad_raddr_q + ADDR_BITWIDTH'(1);
                end
            end
            ST_TAIL:  state_d = ST_FLUSH;
            ST_FLUSH: begin
                state_d = ST_DRAIN;
                cnt_d   = 2'd0;
            end
            ST_DRAIN: begin
                if (cnt_q == 2'd1) begin
                    state_d    = ST_DONE;
                    cnt_d      = 2'd0;
                    out_data_d = capture_value;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default:  state_d = ST_INIT;
        endcase

        // Outputs are decoded from the next state so each registered strobe lines up with its state.
        spad_ren_d    = (state_d == ST_FETCH);
        data_beat_d   = spad_ren_q;
        en_din_d      = spad_ren_q || (state_d == ST_FLUSH) || init_strobe;
        en_dout_d     = (state_d == ST_FLUSH) || init_strobe;
        start_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        out_valid_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            cnt_q         <= 2'd0;
            k_q           <= '0;
            spad_raddr_q  <= '0;
            spad_ren_q    <= 1'b0;
            data_beat_q   <= 1'b0;
            en_din_q      <= 1'b0;
            en_dout_q     <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            spad_raddr_q  <= spad_raddr_d;
            spad_ren_q    <= spad_ren_d;
            data_beat_q   <= data_beat_d;
            en_din_q      <= en_din_d;
            en_dout_q     <= en_dout_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    // Operands are zero outside data beats, so flush and INIT beats feed zeros into the MAC.
    assign mac_iact    = data_beat_q ? spad_iact : '0;
    assign mac_wght    = data_beat_q ? spad_wght : '0;
    assign spad_ren    = spad_ren_q;
    assign spad_raddr  = spad_raddr_q;
    assign en_MAC_din  = en_din_q;
    assign en_MAC_dout = en_dout_q;
    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: two instances (N=49 and N=4) with scratchpad and MAC models.
// Define MAC_SEQ_CTRL_RELU_EN for both RTL and bench to exercise the clamping build.
module tb_mac_seq_ctrl;

    typedef struct {
        int         inst;
        logic [5:0] base;
        logic [7:0] iact;
        logic [7:0] wght;
        bit         ramp;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          inst;
        logic [31:0] value;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        start;
    logic [1:0]        start_ready;
    logic [1:0][5:0]   base_addr;
    logic [1:0]        spad_ren;
    logic [1:0][5:0]   spad_raddr;
    logic [1:0]        en_din;
    logic [1:0]        en_dout;
    logic [1:0][7:0]   mac_iact;
    logic [1:0][7:0]   mac_wght;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
    logic [1:0][31:0]  out_data;
    logic [1:0]        busy;

    logic [7:0] iact_mem [2][64];
    logic [7:0] wght_mem [2][64];

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [5:0] addr_log[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [7:0]  spad_iact;
        logic [7:0]  spad_wght;
        logic [7:0]  iact_r = 8'h5A;
        logic [7:0]  wght_r = 8'h3C;
        logic [31:0] psum   = 32'h0000_1234;
        logic [31:0] dout_r = 32'hDEAD_BEEF;
        logic [31:0] prod;

        assign prod = {{24{iact_r[7]}}, iact_r} * {{24{wght_r[7]}}, wght_r};

        // Scratchpad with one-cycle read latency, plus a MAC with registered operands and psum.
        always @(posedge clk) begin
            if (spad_ren[g]) begin
                spad_iact <= iact_mem[g][spad_raddr[g]];
                spad_wght <= wght_mem[g][spad_raddr[g]];
            end
            if (en_din[g]) begin
                iact_r <= mac_iact[g];
                wght_r <= mac_wght[g];
                psum   <= en_dout[g] ? 32'd0 : psum + prod;
            end
            if (en_dout[g]) dout_r <= psum + prod;
        end

        mac_seq_ctrl #(
            .DATA_BITWIDTH(8),
            .KERNEL_SIZE  (g == 0 ? 49 : 4),
            .ADDR_BITWIDTH(6)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .start_ready(start_ready[g]),
            .base_addr  (base_addr[g]),
            .spad_ren   (spad_ren[g]),
            .spad_raddr (spad_raddr[g]),
            .spad_iact  (spad_iact),
            .spad_wght  (spad_wght),
            .en_MAC_din (en_din[g]),
            .en_MAC_dout(en_dout[g]),
            .mac_iact   (mac_iact[g]),
            .mac_wght   (mac_wght[g]),
            .mac_dout   (dout_r),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_data   (out_data[g]),
            .busy       (busy[g])
        );
    end

    function automatic int ksOf(int inst);
        return (inst == 0) ? 49 : 4;
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: every completed handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (out_valid[i] && out_ready[i]) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected result", out_data[i], 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("result instance", 32'(i), 32'(e.inst));
                    checkOutput("out_data", out_data[i], e.value);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (spad_ren[1]) addr_log.push_back(spad_raddr[1]);
    end

    task automatic waitStartReady(int inst);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready[inst] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("start_ready timeout", 32'(start_ready[inst]), 32'd1);
    endtask

    task automatic startKernel(vec_t v, bit push_exp);
        for (int a = 0; a < 64; a++) begin
            iact_mem[v.inst][a] = v.ramp ? 8'(a) : v.iact;
            wght_mem[v.inst][a] = v.wght;
        end
        waitStartReady(v.inst);
        base_addr[v.inst] = v.base;
        start[v.inst]     = 1'b1;
        @(posedge clk);
        if (push_exp) exp_q.push_back('{inst: v.inst, value: v.exp_data});
        @(negedge clk);
        start[v.inst] = 1'b0;
    endtask

    task automatic applyStimulus(vec_t v);
        int lat;
        startKernel(v, 1'b1);
        lat = 0;
        while (!out_valid[v.inst] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("accept to out_valid latency", 32'(lat), 32'(ksOf(v.inst) + 4));
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] exp_addr [4];
        logic [31:0] neg_a;
        logic [31:0] neg_b;
        int n;

`ifdef MAC_SEQ_CTRL_RELU_EN
        neg_a = 32'd0;
        neg_b = 32'd0;
`else
        neg_a = -32'sd98;
        neg_b = -32'sd790321;
`endif
        vecs[0] = '{inst: 0, base: 6'd0,  iact: 8'd1,  wght: 8'd1,  ramp: 1'b0, exp_data: 32'd49};
        vecs[1] = '{inst: 0, base: 6'd5,  iact: 8'd2,  wght: 8'hFF, ramp: 1'b0, exp_data: neg_a};
        vecs[2] = '{inst: 0, base: 6'd0,  iact: 8'd1,  wght: 8'd1,  ramp: 1'b0, exp_data: 32'd49};
        vecs[3] = '{inst: 0, base: 6'd0,  iact: 8'd0,  wght: 8'd0,  ramp: 1'b0, exp_data: 32'd0};
        vecs[4] = '{inst: 0, base: 6'd17, iact: 8'h80, wght: 8'h80, ramp: 1'b0, exp_data: 32'd802816};
        vecs[5] = '{inst: 0, base: 6'd63, iact: 8'h7F, wght: 8'h81, ramp: 1'b0, exp_data: neg_b};
        vecs[6] = '{inst: 1, base: 6'd62, iact: 8'd0,  wght: 8'd2,  ramp: 1'b1, exp_data: 32'd252};

        rst       = 1'b1;
        start     = 2'b00;
        base_addr = '0;
        out_ready = 2'b11;
        repeat (3) @(negedge clk);
        $display("[TB] checking reset values");
        checkOutput("reset start_ready", 32'(start_ready[0]), 32'd0);
        checkOutput("reset busy", 32'(busy[0]), 32'd1);
        checkOutput("reset spad_ren", 32'(spad_ren[0]), 32'd0);
        checkOutput("reset en_MAC_din", 32'(en_din[0]), 32'd0);
        checkOutput("reset en_MAC_dout", 32'(en_dout[0]), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("reset out_data", out_data[0], 32'd0);
        checkOutput("reset spad_raddr", 32'(spad_raddr[0]), 32'd0);
        checkOutput("reset mac_iact", 32'(mac_iact[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("init strobe en_MAC_din", 32'(en_din[0]), 32'd1);
        checkOutput("init strobe en_MAC_dout", 32'(en_dout[0]), 32'd1);
        checkOutput("init strobe operands", 32'({mac_iact[0], mac_wght[0]}), 32'd0);
        checkOutput("init cycle start_ready", 32'(start_ready[0]), 32'd0);
        @(negedge clk);
        checkOutput("init wait en_MAC_din", 32'(en_din[0]), 32'd0);
        checkOutput("init wait start_ready", 32'(start_ready[0]), 32'd0);
        @(negedge clk);
        checkOutput("idle start_ready", 32'(start_ready[0]), 32'd1);
        checkOutput("idle busy", 32'(busy[0]), 32'd0);

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d", i);
            if (vecs[i].inst == 1) addr_log.delete();
            applyStimulus(vecs[i]);
        end
        exp_addr = '{6'd62, 6'd63, 6'd0, 6'd1};
        checkOutput("wrap address count", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            checkOutput("wrap address", 32'(addr_log[i]), 32'(exp_addr[i]));

        $display("[TB] holding out_ready low in DONE");
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        startKernel(vecs[0], 1'b1);
        n = 0;
        while (!out_valid[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checkOutput("hold out_valid", 32'(out_valid[0]), 32'd1);
            checkOutput("hold out_data", out_data[0], 32'd49);
            checkOutput("hold start_ready", 32'(start_ready[0]), 32'd0);
            start[0] = (j % 2 == 0);
        end
        @(negedge clk);
        start[0] = 1'b0;
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("after hold start_ready", 32'(start_ready[0]), 32'd1);
        checkOutput("after hold out_valid", 32'(out_valid[0]), 32'd0);

        $display("[TB] reset during FETCH");
        startKernel(vecs[0], 1'b0);
        n = 0;
        while (!(spad_ren[0] && spad_raddr[0] == 6'd20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached fetch k=20", 32'(spad_raddr[0]), 32'd20);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort spad_ren", 32'(spad_ren[0]), 32'd0);
        checkOutput("abort busy", 32'(busy[0]), 32'd1);
        checkOutput("abort start_ready", 32'(start_ready[0]), 32'd0);
        checkOutput("abort out_data", out_data[0], 32'd0);
        rst = 1'b0;
        applyStimulus(vecs[0]);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
